// File: rtl/nanov_regfile_scheduler.sv
// Slot scheduler for the nanoV bit-serial register file: one 32-clock slot per
// transaction, core/debug arbitration. Debug requester enabled by NANOV_SCHED_DBG_PORT_EN.
`timescale 1ns/1ps
module nanov_regfile_scheduler #(
    parameter int REG_ADDR_BITS = 4,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     core_valid,
    output logic                     core_ready,
    input  logic [REG_ADDR_BITS-1:0] core_rs1,
    input  logic [REG_ADDR_BITS-1:0] core_rs2,
    input  logic [REG_ADDR_BITS-1:0] core_rd,
    input  logic                     core_wr,
    input  logic                     dbg_valid,
    output logic                     dbg_ready,
    input  logic [REG_ADDR_BITS-1:0] dbg_addr,
    input  logic                     dbg_wr,
    output logic [4:0]               counter,
    output logic [REG_ADDR_BITS-1:0] rs1,
    output logic [REG_ADDR_BITS-1:0] rs2,
    output logic [REG_ADDR_BITS-1:0] rd,
    output logic [REG_ADDR_BITS-1:0] next_rs1,
    output logic [REG_ADDR_BITS-1:0] next_rs2,
    output logic                     wr_en,
    output logic                     wr_next_en,
    output logic                     read_through,
    output logic                     busy,
    output logic                     owner,
    output logic                     slot_done
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RUN     = 1'b1;
    localparam logic [4:0] LAST_BIT   = 5'd31;
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

    logic [0:0] state;
    logic       last_bit;
    logic       window_open;
    logic       core_grant;
    logic       dbg_grant;
    logic       accept;

    assign last_bit    = (state == ST_RUN) && (counter == LAST_BIT);
    // Reset is gated in so nothing can be granted while the slot is being aborted.
    assign window_open = rstn && ((state == ST_IDLE) || last_bit);
    assign core_grant  = core_valid && core_ready;
    assign accept      = core_grant || dbg_grant;

`ifdef NANOV_SCHED_DBG_PORT_EN
    logic [3:0] streak;
    logic       dbg_priority;

    assign dbg_priority = !core_valid || (streak == STREAK_MAX);
    assign dbg_ready    = window_open && dbg_priority;
    assign core_ready   = window_open && !(dbg_valid && dbg_priority);
    assign dbg_grant    = dbg_valid && dbg_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            streak <= '0;
            owner  <= 1'b0;
        end else begin
            if (!dbg_valid || dbg_grant)
                streak <= '0;
            else if (core_grant && (streak != STREAK_MAX))
                streak <= streak + 4'd1;
            if (accept)
                owner <= dbg_grant;
        end
    end
`else
    logic unused_dbg;

    assign unused_dbg = ^{dbg_valid, dbg_addr, dbg_wr, STREAK_MAX};
    assign dbg_ready  = 1'b0;
    assign core_ready = window_open;
    assign dbg_grant  = 1'b0;
    assign owner      = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            counter <= '0;
            rs1     <= '0;
            rs2     <= '0;
            rd      <= '0;
        end else if (accept) begin
            state   <= ST_RUN;
            counter <= '0;
            if (dbg_grant) begin
                rs1 <= dbg_addr;
                rs2 <= '0;
                rd  <= dbg_wr ? dbg_addr : '0;
            end else begin
                rs1 <= core_rs1;
                rs2 <= core_rs2;
                rd  <= core_wr ? core_rd : '0;
            end
        end else if (state == ST_RUN) begin
            if (last_bit) begin
                state   <= ST_IDLE;
                counter <= '0;
            end else begin
                counter <= counter + 5'd1;
            end
        end
    end

    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    always_comb begin
        next_rs1 = rs1;
        next_rs2 = rs2;
        if (dbg_grant) begin
            next_rs1 = dbg_addr;
            next_rs2 = '0;
        end else if (core_grant) begin
            next_rs1 = core_rs1;
            next_rs2 = core_rs2;
        end
    end

    assign busy         = (state == ST_RUN);
    assign wr_next_en   = busy && (rd != '0);
    assign wr_en        = wr_next_en && last_bit;
    assign slot_done    = last_bit;
    assign read_through = wr_en && accept;

endmodule

// File: tb/tb_nanov_regfile_scheduler.sv
// Directed bench for nanov_regfile_scheduler: table of single-slot vectors plus
// hand sequences for back-to-back slots, starvation and mid-slot reset.
`timescale 1ns/1ps
module tb_nanov_regfile_scheduler;

`ifdef NANOV_SCHED_DBG_PORT_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       core_valid, core_wr, dbg_valid, dbg_wr;
    logic [3:0] core_rs1, core_rs2, core_rd, dbg_addr;
    logic       core_ready, dbg_ready;
    logic [4:0] counter;
    logic [3:0] rs1, rs2, rd, next_rs1, next_rs2;
    logic       wr_en, wr_next_en, read_through, busy, owner, slot_done;

    int checks = 0;
    int errors = 0;

    nanov_regfile_scheduler #(.REG_ADDR_BITS(4), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rstn(rstn),
        .core_valid(core_valid), .core_ready(core_ready),
        .core_rs1(core_rs1), .core_rs2(core_rs2), .core_rd(core_rd), .core_wr(core_wr),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_wr(dbg_wr),
        .counter(counter), .rs1(rs1), .rs2(rs2), .rd(rd),
        .next_rs1(next_rs1), .next_rs2(next_rs2),
        .wr_en(wr_en), .wr_next_en(wr_next_en), .read_through(read_through),
        .busy(busy), .owner(owner), .slot_done(slot_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [3:0] c_rs1, c_rs2, c_rd;
        logic       c_wr;
        logic       dv;
        logic [3:0] d_addr;
        logic       d_wr;
        logic       e_core_rdy, e_dbg_rdy;
        logic [3:0] e_nrs1, e_nrs2;
        logic       e_acc;
        logic [3:0] e_rs1, e_rs2, e_rd;
        logic       e_owner;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        core_valid = 1'b0; core_rs1 = '0; core_rs2 = '0; core_rd = '0; core_wr = 1'b0;
        dbg_valid  = 1'b0; dbg_addr = '0; dbg_wr = 1'b0;
    endtask

    task automatic drive_core(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d, input logic w);
        core_valid = 1'b1; core_rs1 = a; core_rs2 = b; core_rd = d; core_wr = w;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic w;
        logic seen;

        vecs[0] = '{1, 1, 2, 5, 1, 0, 0, 0, 1, 0, 1, 2, 1, 1, 2, 5, 0};
        vecs[1] = '{1, 3, 4, 6, 0, 0, 0, 0, 1, 0, 3, 4, 1, 3, 4, 0, 0};
        if (DBG) begin
            vecs[2] = '{0, 0, 0, 0, 0, 1, 9, 1, 0, 1, 9, 0, 1, 9, 0, 9, 1};
            vecs[3] = '{0, 0, 0, 0, 0, 1, 10, 0, 0, 1, 10, 0, 1, 10, 0, 0, 1};
        end else begin
            vecs[2] = '{0, 0, 0, 0, 0, 1, 9, 1, 1, 0, 3, 4, 0, 3, 4, 0, 0};
            vecs[3] = '{0, 0, 0, 0, 0, 1, 10, 0, 1, 0, 3, 4, 0, 3, 4, 0, 0};
        end
        vecs[4] = '{1, 11, 12, 13, 1, 1, 14, 1, 1, 0, 11, 12, 1, 11, 12, 13, 0};
        vecs[5] = '{1, 5, 6, 0, 1, 0, 0, 0, 1, 0, 5, 6, 1, 5, 6, 0, 0};

        // Reset state
        rstn = 1'b0;
        idle_inputs();
        repeat (3) tick();
        check("rst_counter", counter, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_next_en", wr_next_en, 0);
        check("rst_read_through", read_through, 0);
        check("rst_owner", owner, 0);
        check("rst_slot_done", slot_done, 0);
        check("rst_rs", {rs1, rs2, rd}, 0);
        check("rst_next_rs", {next_rs1, next_rs2}, 0);
        rstn = 1'b1;
        settle();
        check("idle_core_ready", core_ready, 1);
        check("idle_dbg_ready", dbg_ready, DBG);
        tick();

        // Table: one request from IDLE, then the full slot
        for (int i = 0; i < 6; i++) begin
            core_valid = vecs[i].cv; core_rs1 = vecs[i].c_rs1; core_rs2 = vecs[i].c_rs2;
            core_rd = vecs[i].c_rd; core_wr = vecs[i].c_wr;
            dbg_valid = vecs[i].dv; dbg_addr = vecs[i].d_addr; dbg_wr = vecs[i].d_wr;
            settle();
            check($sformatf("v%0d_core_ready", i), core_ready, vecs[i].e_core_rdy);
            check($sformatf("v%0d_dbg_ready", i), dbg_ready, vecs[i].e_dbg_rdy);
            check($sformatf("v%0d_next_rs1", i), next_rs1, vecs[i].e_nrs1);
            check($sformatf("v%0d_next_rs2", i), next_rs2, vecs[i].e_nrs2);
            tick();
            idle_inputs();
            if (vecs[i].e_acc) begin
                check($sformatf("v%0d_busy", i), busy, 1);
                check($sformatf("v%0d_rs1", i), rs1, vecs[i].e_rs1);
                check($sformatf("v%0d_rs2", i), rs2, vecs[i].e_rs2);
                check($sformatf("v%0d_rd", i), rd, vecs[i].e_rd);
                check($sformatf("v%0d_owner", i), owner, vecs[i].e_owner);
                w = (vecs[i].e_rd != 4'd0);
                for (int c = 0; c < 32; c++) begin
                    check($sformatf("v%0d_c%0d_counter", i, c), counter, c);
                    check($sformatf("v%0d_c%0d_wr_next_en", i, c), wr_next_en, w);
                    check($sformatf("v%0d_c%0d_wr_en", i, c), wr_en, (c == 31) && w);
                    check($sformatf("v%0d_c%0d_slot_done", i, c), slot_done, c == 31);
                    if (c < 31) tick();
                end
                check($sformatf("v%0d_last_read_through", i), read_through, 0);
                tick();
            end
            check($sformatf("v%0d_end_busy", i), busy, 0);
            check($sformatf("v%0d_end_counter", i), counter, 0);
        end

        // Back-to-back writes with read-through and no bubble
        drive_core(4'd1, 4'd2, 4'd7, 1'b1);
        settle();
        tick();
        idle_inputs();
        check("b2b_rd1", rd, 7);
        repeat (5) tick();
        drive_core(4'd9, 4'd9, 4'd9, 1'b1);
        settle();
        check("b2b_closed_core_ready", core_ready, 0);
        check("b2b_closed_next_rs1", next_rs1, 1);
        idle_inputs();
        repeat (26) tick();
        check("b2b_counter31", counter, 31);
        drive_core(4'd7, 4'd3, 4'd8, 1'b1);
        settle();
        check("b2b_core_ready", core_ready, 1);
        check("b2b_dbg_ready", dbg_ready, 0);
        check("b2b_next_rs1", next_rs1, 7);
        check("b2b_next_rs2", next_rs2, 3);
        check("b2b_read_through", read_through, 1);
        check("b2b_wr_en", wr_en, 1);
        tick();
        idle_inputs();
        check("b2b_counter0", counter, 0);
        check("b2b_busy", busy, 1);
        check("b2b_rs1", rs1, 7);
        check("b2b_rd2", rd, 8);
        repeat (31) tick();
        check("b2b2_counter31", counter, 31);
        check("b2b2_wr_en", wr_en, 1);
        check("b2b2_read_through", read_through, 0);
        tick();
        check("b2b_end_busy", busy, 0);

        // Starvation: core and debug both held valid
        drive_core(4'd2, 4'd3, 4'd0, 1'b0);
        dbg_valid = 1'b1; dbg_addr = 4'd12; dbg_wr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("starve_s%0d_owner", k), owner, DBG && (k == 4 || k == 9));
            check($sformatf("starve_s%0d_rs1", k), rs1, (DBG && (k == 4 || k == 9)) ? 12 : 2);
            check($sformatf("starve_s%0d_counter", k), counter, 0);
            repeat (31) tick();
        end
        idle_inputs();
        tick();
        check("starve_end_busy", busy, 0);

        // Reset mid-slot
        drive_core(4'd1, 4'd2, 4'd5, 1'b1);
        settle();
        tick();
        idle_inputs();
        repeat (10) tick();
        check("mrst_counter10", counter, 10);
        rstn = 1'b0;
        tick();
        check("mrst_busy", busy, 0);
        check("mrst_counter", counter, 0);
        check("mrst_wr_next_en", wr_next_en, 0);
        rstn = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (wr_en || busy) seen = 1'b1;
            tick();
        end
        check("mrst_no_write", seen, 0);
        drive_core(4'd4, 4'd6, 4'd3, 1'b1);
        settle();
        check("mrst_fresh_ready", core_ready, 1);
        tick();
        idle_inputs();
        check("mrst_fresh_busy", busy, 1);
        check("mrst_fresh_rs1", rs1, 4);
        check("mrst_fresh_rd", rd, 3);
        repeat (31) tick();
        check("mrst_fresh_wr_en", wr_en, 1);
        tick();
        check("mrst_fresh_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nanov_regfile_scheduler.md
Name: nanov_regfile_scheduler

Overview:
- Slot scheduler for the nanoV bit-serial register file.
- Each register-file transaction occupies one 32-clock "slot".
- Arbitrates between two requesters: the core pipeline (normal priority) and a debug port.
- Drives the register file's addresses, bit counter, write enables and read-through control, and issues slots back-to-back with no bubble.

Parameters:
- REG_ADDR_BITS, 4, width of register addresses.
- STARVE_LIMIT, 4, consecutive core slots granted while debug waits before debug is forced in (range 1..15).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- core_valid  in  1  core requests a slot
- core_ready  out  1  core request accepted this cycle when valid&&ready
- core_rs1  in  REG_ADDR_BITS  core source 1
- core_rs2  in  REG_ADDR_BITS  core source 2
- core_rd  in  REG_ADDR_BITS  core destination
- core_wr  in  1  core slot writes rd
- dbg_valid  in  1  debug requests a slot
- dbg_ready  out  1  debug request accepted when valid&&ready
- dbg_addr  in  REG_ADDR_BITS  debug register (used as rs1 and rd)
- dbg_wr  in  1  debug slot writes dbg_addr
- counter  out  5  bit index of current slot
- rs1  out  REG_ADDR_BITS  current slot rs1
- rs2  out  REG_ADDR_BITS  current slot rs2
- rd  out  REG_ADDR_BITS  current slot rd
- next_rs1  out  REG_ADDR_BITS  rs1 of the slot starting next clock
- next_rs2  out  REG_ADDR_BITS  rs2 of the slot starting next clock
- wr_en  out  1  final-bit write strobe
- wr_next_en  out  1  streaming write enable
- read_through  out  1  forward the current rd into the next slot
- busy  out  1  a slot is in progress
- owner  out  1  0 = core, 1 = debug, for the current slot
- slot_done  out  1  one-cycle pulse on the last cycle of a slot

Behaviour:
- Reset (rstn=0 at posedge):
  - state IDLE; counter=0.
  - rs1/rs2/rd/next_rs1/next_rs2=0.
  - wr_en, wr_next_en, read_through, busy, owner, slot_done = 0.
  - Streak counter = 0.
  - Reset mid-slot aborts the slot with no further write strobes.
- States: IDLE, RUN.
- Accept window: "open" when state==IDLE, or when state==RUN and counter==31. core_ready/dbg_ready are only asserted while the window is open.
- Arbitration inside an open window:
  - Debug wins if dbg_valid && (!core_valid || streak==STARVE_LIMIT).
  - Otherwise core wins if core_valid.
  - The loser's ready is 0. At most one ready is high per cycle.
  - Streak: increments on a core grant while dbg_valid=1; clears on a debug grant or when dbg_valid=0. Saturates at STARVE_LIMIT.
- Accept at cycle T:
  - At T+1: state=RUN, counter=0, rs1/rs2/rd/owner/write flag latched.
  - Debug latching: rs1=dbg_addr, rs2=0, rd=(dbg_wr?dbg_addr:0).
  - Core latching: rd=(core_wr?core_rd:0).
  - counter increments each clock and reaches 31 at T+32.
  - slot_done=1 at T+32.
  - If no accept at counter==31: IDLE at T+33, counter returns to 0.
- next_rs1/next_rs2:
  - Combinational.
  - Equal to the winning request's rs when an accept occurs this cycle.
  - Otherwise equal to the current rs1/rs2.
- Writes:
  - wr_next_en=1 for all RUN cycles of a slot with rd!=0.
  - wr_en=1 only at counter==31 of such a slot.
  - rd==0 suppresses both.
- read_through:
  - 1 only at counter==31 of a writing slot (rd!=0) when an accept occurs in the same cycle.
  - Otherwise 0.
  - The register file performs the rs/rd match itself.
- busy=1 in RUN.
- Simultaneous core and debug valid with streak<STARVE_LIMIT: core wins.
- Inputs are sampled only on accept; they may change freely afterwards.

Optional Feature:
- Macro NANOV_SCHED_DBG_PORT_EN.
- When defined: debug requester, streak logic and owner behave as above.
- When undefined:
  - dbg_ready is tied to 0 and owner is tied to 0.
  - dbg_* inputs are ignored and the streak counter is removed.
  - Core timing is unchanged.

Test Plan:
- Reset, then idle: counter=0, all strobes 0, core_ready=1, dbg_ready=1 while no request is pending.
- Single core write, rd=5, rs1=1, rs2=2, accepted at T → counter 0..31 over T+1..T+32; wr_next_en=1 throughout; wr_en and slot_done only at T+32; IDLE at T+33.
- Back-to-back core slots: write rd=7, then rs1=7 offered at counter==31 → next_rs1=7 and read_through=1 in that cycle; second slot has counter=0 at the next clock with no bubble.
- Core write with rd=0 → wr_en and wr_next_en stay 0 for the whole slot; read_through stays 0.
- Core and debug both continuously valid, STARVE_LIMIT=4 → grant order core×4, debug, core×4, debug; owner=1 only during debug slots.
- Reset asserted at counter=10 of a write slot → next cycle IDLE, counter=0, no wr_en pulse; a fresh request is accepted normally.
